vga_timing_scaler: RTL and testbench
====================================

// Module: vga_timing_scaler
// PURPOSE
//  Parametrised VGA raster generator and integer up-scaler for the NES frame buffer.
//  - Walks a programmable H/V raster and issues frame-buffer read addresses for a
//    SRC_W x SRC_H image placed at (X_OFFSET, Y_OFFSET), replicated X_SCALE x Y_SCALE.
//  - Aligns returned pixel data with registered hsync/vsync/de over a fixed read latency.
//  - Adds vblank/frame_start outputs for PPU/CPU NMI timing.
// PARAMETERS
//  RGB_W     9    pixel colour width (3b R, 3b G, 3b B at default)
//  H_ACTIVE  320  visible pixel clocks per line
//  H_FP      8    horizontal front porch, in clocks
//  H_SYNC    48   hsync width, in clocks
//  H_BP      24   horizontal back porch, in clocks
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vsync width, in lines
//  V_BP      33   vertical back porch, in lines
//  SRC_W     256  source image width, in pixels
//  SRC_H     240  source image height, in lines
//  X_SCALE   1    horizontal replication factor (>=1)
//  Y_SCALE   2    vertical replication factor (>=1)
//  X_OFFSET  32   first active column of the image window
//  Y_OFFSET  0    first active line of the image window
//  SYNC_POL  0    sync asserted level (0 = active-low)
//  RD_LAT    1    frame-buffer read latency in clocks (>=1)
// PORTS
//  pix_clk     in   1              pixel clock
//  rst_n       in   1              asynchronous active-low reset
//  rgb_buf     in   RGB_W          frame-buffer read data, valid RD_LAT clocks after rd_en
//  rd_en       out  1              address valid (cursor inside image window)
//  pix_ptr_x   out  $clog2(SRC_W)  source column address
//  pix_ptr_y   out  $clog2(SRC_H)  source row address
//  rgb         out  RGB_W          pixel output, 0 outside the image window
//  hsync       out  1              horizontal sync, SYNC_POL level while asserted
//  vsync       out  1              vertical sync, SYNC_POL level while asserted
//  de          out  1              inside active H_ACTIVE x V_ACTIVE area
//  vblank      out  1              high while line >= V_ACTIVE
//  frame_start out  1              one-clock pulse for raster position (0,0)
// BEHAVIOUR
//  Counters
//  - h_cnt 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; the default is 400.
//  - v_cnt 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; the default is 525.
//  - v_cnt advances only on the h_cnt wrap. Both counters wrap to 0 together at the end of the frame.
//  Image window
//  - In window when X_OFFSET <= h_cnt < X_OFFSET+SRC_W*X_SCALE
//    and Y_OFFSET <= v_cnt < Y_OFFSET+SRC_H*Y_SCALE.
//  Address generation
//  - No dividers. A sub-counter x_rep repeats each column X_SCALE times; y_rep repeats each row Y_SCALE times.
//  - pix_ptr_x increments when x_rep wraps and clears at window entry on every line.
//  - pix_ptr_y increments when y_rep wraps at the end of each in-window line. It clears at frame wrap.
//  Address timing
//  - rd_en, pix_ptr_x and pix_ptr_y are combinational from the counter state (stage 0).
//  - Outside the window: rd_en=0 and both pointers are 0.
//  Output pipeline (stage RD_LAT+1)
//  - Counter position n at cycle t yields registered rgb/hsync/vsync/de/vblank/frame_start at t+RD_LAT+1.
//  - The window flag is delayed RD_LAT clocks. rgb <= delayed_window ? rgb_buf : 0.
//  - hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
//  - vsync asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync is a whole-line signal.
//  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//  - frame_start = (h_cnt==0) && (v_cnt==0).
//  Reset (async assert, sync release)
//  - All counters, sub-counters and pointers are 0.
//  - Delay-line contents are cleared to the blank/inactive state.
//  - Output values during reset: rgb=0, de=0, vblank=0, frame_start=0, hsync=vsync=~SYNC_POL.
//  - The first frame_start pulse occurs RD_LAT+1 clocks after release. Mid-frame reset aborts the frame.
//  Parameter constraints
//  - Elaboration $error if X_OFFSET+SRC_W*X_SCALE > H_ACTIVE, Y_OFFSET+SRC_H*Y_SCALE > V_ACTIVE,
//    RD_LAT < 1, or any scale is 0.
//  Defaults reproduce the 12.5 MHz, 640x480@60 timing:
//  - 32-clock black borders on both sides; each NES line is shown twice.
// TESTING
//  1 Defaults, reset release -> frame_start pulses at clk 2, then every 210000 clks (400*525).
//  2 Defaults, h_cnt sweep -> hsync low for h_cnt 328..375.
//    The same sweep at the outputs gives rd_en for h_cnt 32..287 with pix_ptr_x 0..255.
//  3 Defaults -> vsync low only on lines 490..491; vblank high from line 480 to 524.
//    The same run shows pix_ptr_y repeating each value for 2 lines, reaching 239 on lines 478..479.
//  4 RD_LAT=3, rgb_buf = {pix_ptr_y[0],pix_ptr_x} delayed 3 clks -> rgb at h_cnt 32 output shows column 0.
//    hsync shifts by the same 4 clks.
//  5 X_SCALE=2, SRC_W=128 -> each pix_ptr_x value is held for 2 clks; rgb is 0 outside h_cnt 32..287.
//  6 rst_n pulsed low at line 200 -> outputs go to reset values immediately.
//    After release, the counters restart at (0,0) and frame_start fires after RD_LAT+1 clks.

Source files
------------

// File: rtl/vga_timing_scaler.sv
// VGA raster generator with integer up-scaling of a frame-buffer image window.
// Addresses are issued combinationally; sync/blank/pixel outputs are registered RD_LAT+1 clocks later.
module vga_timing_scaler #(
  parameter int RGB_W    = 9,
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 24,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SRC_W    = 256,
  parameter int SRC_H    = 240,
  parameter int X_SCALE  = 1,
  parameter int Y_SCALE  = 2,
  parameter int X_OFFSET = 32,
  parameter int Y_OFFSET = 0,
  parameter int SYNC_POL = 0,
  parameter int RD_LAT   = 1
) (
  input  logic                     pix_clk,
  input  logic                     rst_n,
  input  logic [RGB_W-1:0]         rgb_buf,
  output logic                     rd_en,
  output logic [$clog2(SRC_W)-1:0] pix_ptr_x,
  output logic [$clog2(SRC_H)-1:0] pix_ptr_y,
  output logic [RGB_W-1:0]         rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic                     vblank,
  output logic                     frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int XW  = $clog2(SRC_W);
  localparam int YW  = $clog2(SRC_H);
  localparam int XRW = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
  localparam int YRW = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;
  localparam logic SYNC_ON = (SYNC_POL != 0);

  if (X_OFFSET + SRC_W * X_SCALE > H_ACTIVE) begin : g_bad_x
    $error("image window exceeds H_ACTIVE");
  end
  if (Y_OFFSET + SRC_H * Y_SCALE > V_ACTIVE) begin : g_bad_y
    $error("image window exceeds V_ACTIVE");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("RD_LAT must be at least 1");
  end
  if (X_SCALE < 1 || Y_SCALE < 1) begin : g_bad_scale
    $error("scale factors must be at least 1");
  end

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [XRW-1:0] x_rep;
  logic [YRW-1:0] y_rep;
  logic [XW-1:0]  ptr_x;
  logic [YW-1:0]  ptr_y;

  logic h_last, v_last, x_in, y_in, win;
  logic hs_on, vs_on, de_on, vb_on, fs_on;

  // Offset-subtract compares: a cursor before the offset wraps to a large value and falls out.
  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));
  assign x_in   = (h_cnt - HW'(X_OFFSET)) < HW'(SRC_W * X_SCALE);
  assign y_in   = (v_cnt - VW'(Y_OFFSET)) < VW'(SRC_H * Y_SCALE);
  assign win    = x_in && y_in;
  assign hs_on  = (h_cnt - HW'(H_ACTIVE + H_FP)) < HW'(H_SYNC);
  assign vs_on  = (v_cnt - VW'(V_ACTIVE + V_FP)) < VW'(V_SYNC);
  assign de_on  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign vb_on  = (v_cnt >= VW'(V_ACTIVE));
  assign fs_on  = (h_cnt == '0) && (v_cnt == '0);

  // rd_en is a valid-only strobe (no ready): the frame buffer must return data RD_LAT clocks later.
  assign rd_en     = win;
  assign pix_ptr_x = win ? ptr_x : '0;
  assign pix_ptr_y = win ? ptr_y : '0;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      x_rep <= '0;
      y_rep <= '0;
      ptr_x <= '0;
      ptr_y <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + VW'(1);

      if (win) begin
        if (x_rep == XRW'(X_SCALE - 1)) begin
          x_rep <= '0;
          ptr_x <= ptr_x + XW'(1);
        end else begin
          x_rep <= x_rep + XRW'(1);
        end
      end else begin
        x_rep <= '0;
        ptr_x <= '0;
      end

      if (h_last) begin
        if (v_last) begin
          y_rep <= '0;
          ptr_y <= '0;
        end else if (y_in) begin
          if (y_rep == YRW'(Y_SCALE - 1)) begin
            y_rep <= '0;
            ptr_y <= ptr_y + YW'(1);
          end else begin
            y_rep <= y_rep + YRW'(1);
          end
        end
      end
    end
  end

  // Delay line bits: {window, hsync, vsync, de, vblank, frame_start}, all active-high.
  logic [5:0] dly [RD_LAT];
  logic [5:0] tail;
  assign tail = dly[RD_LAT-1];

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= '0;
      rgb         <= '0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      de          <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      dly[0] <= {win, hs_on, vs_on, de_on, vb_on, fs_on};
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
      rgb         <= tail[5] ? rgb_buf : '0;
      hsync       <= tail[4] ? SYNC_ON : ~SYNC_ON;
      vsync       <= tail[3] ? SYNC_ON : ~SYNC_ON;
      de          <= tail[2];
      vblank      <= tail[1];
      frame_start <= tail[0];
    end
  end
endmodule

// File: tb/tb_vga_timing_scaler.sv
// Bench for vga_timing_scaler on a shrunken raster: spot-check table plus a division-based
// reference model of raster position, window mapping and the output latency.
module tb_vga_timing_scaler;
  localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
  localparam int SW = 16, SH = 10, XS = 2, YS = 2, XO = 4, YO = 3;
  localparam int LAT = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] rgb_buf;
  logic       rd_en;
  logic [3:0] pix_ptr_x, pix_ptr_y;
  logic [8:0] rgb;
  logic       hsync, vsync, de, vblank, frame_start;

  vga_timing_scaler #(
    .RGB_W(9), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SRC_W(SW), .SRC_H(SH), .X_SCALE(XS), .Y_SCALE(YS),
    .X_OFFSET(XO), .Y_OFFSET(YO), .SYNC_POL(0), .RD_LAT(LAT)
  ) dut (
    .pix_clk(clk), .rst_n(rst_n), .rgb_buf(rgb_buf), .rd_en(rd_en),
    .pix_ptr_x(pix_ptr_x), .pix_ptr_y(pix_ptr_y), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v;
    logic rd; logic [3:0] px; logic [3:0] py;
    logic hs; logic vs; logic de; logic vb; logic fs;
  } vec_t;

  vec_t       tbl [20];
  logic [8:0] mem [16][16];
  logic [8:0] rdq [$];
  int         pos;
  bit         tbl_en;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s pos=%0d got=%0h exp=%0h", name, p, act, exp);
  endtask

  function automatic bit in_win(input int h, input int v);
    return h >= XO && h < XO + SW * XS && v >= YO && v < YO + SH * YS;
  endfunction

  task automatic check_reset();
    chk("rst_rgb", pos, rgb, 0);
    chk("rst_hsync", pos, hsync, 1);
    chk("rst_vsync", pos, vsync, 1);
    chk("rst_de", pos, de, 0);
    chk("rst_vblank", pos, vblank, 0);
    chk("rst_fs", pos, frame_start, 0);
    chk("rst_rd_en", pos, rd_en, 0);
    chk("rst_ptr_x", pos, pix_ptr_x, 0);
    chk("rst_ptr_y", pos, pix_ptr_y, 0);
  endtask

  task automatic check_cycle();
    int h, v, q, h2, v2;
    bit w, w2;
    logic [8:0] rgb_e;
    q = pos % FT; h = q % HT; v = q / HT;
    w = in_win(h, v);
    chk("rd_en", pos, rd_en, w);
    chk("ptr_x", pos, pix_ptr_x, w ? (h - XO) / XS : 0);
    chk("ptr_y", pos, pix_ptr_y, w ? (v - YO) / YS : 0);
    if (pos < LAT + 1) begin
      chk("rgb", pos, rgb, 0);
      chk("hsync", pos, hsync, 1);
      chk("vsync", pos, vsync, 1);
      chk("de", pos, de, 0);
      chk("vblank", pos, vblank, 0);
      chk("frame_start", pos, frame_start, 0);
    end else begin
      q = (pos - LAT - 1) % FT; h2 = q % HT; v2 = q / HT;
      w2 = in_win(h2, v2);
      rgb_e = w2 ? mem[(v2 - YO) / YS][(h2 - XO) / XS] : 9'd0;
      chk("rgb", pos, rgb, rgb_e);
      chk("hsync", pos, hsync, (h2 >= HA + HFP && h2 < HA + HFP + HS) ? 0 : 1);
      chk("vsync", pos, vsync, (v2 >= VA + VFP && v2 < VA + VFP + VS) ? 0 : 1);
      chk("de", pos, de, (h2 < HA && v2 < VA) ? 1 : 0);
      chk("vblank", pos, vblank, (v2 >= VA) ? 1 : 0);
      chk("frame_start", pos, frame_start, (h2 == 0 && v2 == 0) ? 1 : 0);
    end
    if (tbl_en) begin
      for (int i = 0; i < 20; i++) begin
        int c;
        c = tbl[i].v * HT + tbl[i].h;
        if (pos == c) begin
          chk("tbl_rd_en", pos, rd_en, tbl[i].rd);
          chk("tbl_ptr_x", pos, pix_ptr_x, tbl[i].px);
          chk("tbl_ptr_y", pos, pix_ptr_y, tbl[i].py);
        end
        if (pos == c + LAT + 1) begin
          chk("tbl_hsync", pos, hsync, tbl[i].hs);
          chk("tbl_vsync", pos, vsync, tbl[i].vs);
          chk("tbl_de", pos, de, tbl[i].de);
          chk("tbl_vblank", pos, vblank, tbl[i].vb);
          chk("tbl_fs", pos, frame_start, tbl[i].fs);
        end
      end
    end
  endtask

  // Frame-buffer model: returns the addressed word RD_LAT clocks after the read, junk otherwise.
  task automatic drive_buf();
    logic [8:0] d;
    d = rd_en ? mem[pix_ptr_y][pix_ptr_x] : 9'($urandom);
    rdq.push_back(d);
    if (rdq.size() > LAT + 1) void'(rdq.pop_front());
    rgb_buf = (rdq.size() == LAT + 1) ? rdq[0] : 9'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos++;
    check_cycle();
    drive_buf();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rdq.delete();
    pos = 0;
    check_cycle();
    drive_buf();
  endtask

  initial begin
    int target;
    //          h   v  rd  px     py    hs  vs  de  vb  fs
    tbl[0]  = '{0,  0,  0, 4'd0,  4'd0, 1, 1, 1, 0, 1};
    tbl[1]  = '{3,  3,  0, 4'd0,  4'd0, 1, 1, 1, 0, 0};
    tbl[2]  = '{4,  3,  1, 4'd0,  4'd0, 1, 1, 1, 0, 0};
    tbl[3]  = '{5,  3,  1, 4'd0,  4'd0, 1, 1, 1, 0, 0};
    tbl[4]  = '{6,  3,  1, 4'd1,  4'd0, 1, 1, 1, 0, 0};
    tbl[5]  = '{35, 3,  1, 4'd15, 4'd0, 1, 1, 1, 0, 0};
    tbl[6]  = '{36, 3,  0, 4'd0,  4'd0, 1, 1, 1, 0, 0};
    tbl[7]  = '{4,  4,  1, 4'd0,  4'd0, 1, 1, 1, 0, 0};
    tbl[8]  = '{4,  5,  1, 4'd0,  4'd1, 1, 1, 1, 0, 0};
    tbl[9]  = '{43, 10, 0, 4'd0,  4'd0, 1, 1, 0, 0, 0};
    tbl[10] = '{44, 10, 0, 4'd0,  4'd0, 0, 1, 0, 0, 0};
    tbl[11] = '{49, 10, 0, 4'd0,  4'd0, 0, 1, 0, 0, 0};
    tbl[12] = '{50, 10, 0, 4'd0,  4'd0, 1, 1, 0, 0, 0};
    tbl[13] = '{35, 22, 1, 4'd15, 4'd9, 1, 1, 1, 0, 0};
    tbl[14] = '{4,  23, 0, 4'd0,  4'd0, 1, 1, 1, 0, 0};
    tbl[15] = '{39, 29, 0, 4'd0,  4'd0, 1, 1, 1, 0, 0};
    tbl[16] = '{0,  30, 0, 4'd0,  4'd0, 1, 1, 0, 1, 0};
    tbl[17] = '{0,  32, 0, 4'd0,  4'd0, 1, 0, 0, 1, 0};
    tbl[18] = '{55, 33, 0, 4'd0,  4'd0, 1, 0, 0, 1, 0};
    tbl[19] = '{0,  34, 0, 4'd0,  4'd0, 1, 1, 0, 1, 0};
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) mem[y][x] = 9'($urandom);

    // Clock/reset: hold reset, check reset values, release between edges.
    rst_n = 1'b0;
    rgb_buf = '0;
    pos = 0;
    tbl_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();

    tbl_en = 1'b1;
    release_reset();
    while (pos < FT) step();
    tbl_en = 1'b0;

    // Run into the second frame, then abort it mid-frame with an asynchronous reset.
    target = FT + $urandom_range(10, 20) * HT + $urandom_range(0, HT - 1);
    while (pos < target) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset();
    end

    release_reset();
    while (pos < FT + 50) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
